// File: rtl/reg_write_ctrl_pkg.sv
// reg_ctrl_pkg: shared sizes, FSM encoding and reset constants for the register-file write controller.
package reg_ctrl_pkg;
   localparam int ADDR_W   = 3;
   localparam int DATA_W   = 8;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef enum logic {
      IDLE = 1'b0,
      CLR  = 1'b1
   } state_t;

   localparam logic LAST_RST = 1'b1;
endpackage

// File: rtl/reg_write_ctrl_if.sv
// reg_write_ctrl_if: requester, clear and register-file write signals of the write-port controller.
interface reg_write_ctrl_if
   import reg_ctrl_pkg::*;
#(
   parameter int AW = ADDR_W,
   parameter int DW = DATA_W
);
   logic          REQ0;
   logic [AW-1:0] ADDR0;
   logic [DW-1:0] DATA0;
   logic          GNT0;
   logic          REQ1;
   logic [AW-1:0] ADDR1;
   logic [DW-1:0] DATA1;
   logic          GNT1;
   logic          CLEAR;
   logic          BUSY;
   logic          WRITE;
   logic [AW-1:0] INADDRESS;
   logic [DW-1:0] IN;

   modport master (
      output REQ0, ADDR0, DATA0, REQ1, ADDR1, DATA1, CLEAR,
      input  GNT0, GNT1, BUSY, WRITE, INADDRESS, IN
   );

   modport slave (
      input  REQ0, ADDR0, DATA0, REQ1, ADDR1, DATA1, CLEAR,
      output GNT0, GNT1, BUSY, WRITE, INADDRESS, IN
   );
endinterface

// File: rtl/reg_write_ctrl_rr_arb2.sv
// rr_arb2: combinational two-way round-robin arbiter; on contention the port other than last wins.
module rr_arb2 (
   input  logic       req0,
   input  logic       req1,
   input  logic       last,
   output logic [1:0] gnt
);
   always_comb begin
      gnt[0] = req0 & (~req1 | last);
      gnt[1] = req1 & (~req0 | ~last);
   end
endmodule

// File: rtl/reg_write_ctrl.sv
// reg_write_ctrl: shares the register-file write port between two requesters and runs a sequenced clear.
// Optional macro PROTECT_R0_EN: requester writes to register 0 are granted but suppressed.
module reg_write_ctrl
   import reg_ctrl_pkg::*;
(
   input logic             CLK,
   input logic             RESET,
   reg_write_ctrl_if.slave bus
);
   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic              last;
   logic [1:0]        gnt;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic              wr_ok;

   rr_arb2 u_arb (
      .req0 (bus.REQ0),
      .req1 (bus.REQ1),
      .last (last),
      .gnt  (gnt)
   );

   assign sel_addr = gnt[1] ? bus.ADDR1 : bus.ADDR0;
   assign sel_data = gnt[1] ? bus.DATA1 : bus.DATA0;

`ifdef PROTECT_R0_EN
   assign wr_ok = |sel_addr;
`else
   assign wr_ok = 1'b1;
`endif

   // cnt tracks the address of the clear write currently being presented
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state         <= IDLE;
         cnt           <= '0;
         last          <= LAST_RST;
         bus.GNT0      <= 1'b0;
         bus.GNT1      <= 1'b0;
         bus.WRITE     <= 1'b0;
         bus.BUSY      <= 1'b0;
         bus.INADDRESS <= '0;
         bus.IN        <= '0;
      end else begin
         bus.GNT0  <= 1'b0;
         bus.GNT1  <= 1'b0;
         bus.WRITE <= 1'b0;
         if (state == IDLE && bus.CLEAR) begin
            state         <= CLR;
            cnt           <= '0;
            bus.BUSY      <= 1'b1;
            bus.WRITE     <= 1'b1;
            bus.INADDRESS <= '0;
            bus.IN        <= '0;
         end else if (state == CLR && cnt != ADDR_W'(NUM_REGS - 1)) begin
            cnt           <= cnt + 1'b1;
            bus.WRITE     <= 1'b1;
            bus.INADDRESS <= cnt + 1'b1;
            bus.IN        <= '0;
         end else begin
            state    <= IDLE;
            cnt      <= '0;
            bus.BUSY <= 1'b0;
            if (|gnt) begin
               bus.GNT0      <= gnt[0];
               bus.GNT1      <= gnt[1];
               bus.WRITE     <= wr_ok;
               bus.INADDRESS <= sel_addr;
               bus.IN        <= sel_data;
               last          <= gnt[1];
            end
         end
      end
   end
endmodule

// File: tb/tb_reg_write_ctrl.sv
// tb_reg_write_ctrl: directed scoreboard bench for reg_write_ctrl with a behavioural register file.
module tb_reg_write_ctrl;
   import reg_ctrl_pkg::*;

   typedef struct packed {
      logic              g0;
      logic              g1;
      logic              w;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } ev_t;

   logic CLK = 1'b0;
   logic RESET = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   busy_cnt = 0;
   ev_t  q[$];
   logic [DATA_W-1:0] rf [NUM_REGS];

   reg_write_ctrl_if bus ();

   reg_write_ctrl dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic ev_t ev(input logic g0, input logic g1, input logic w,
                              input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      ev_t e;
      e = '{g0: g0, g1: g1, w: w, a: a, d: d};
      return e;
   endfunction

   always @(posedge CLK)
      if (RESET && bus.WRITE) rf[bus.INADDRESS] <= bus.IN;

   always @(negedge CLK) begin
      if (bus.BUSY) busy_cnt++;
      if (bus.GNT0 || bus.GNT1 || bus.WRITE) begin
         if (q.size() == 0)
            chk("unexpected_output", 32'(ev(bus.GNT0, bus.GNT1, bus.WRITE, bus.INADDRESS, bus.IN)), 32'hFFFF_FFFF);
         else
            chk("sb_event", 32'(ev(bus.GNT0, bus.GNT1, bus.WRITE, bus.INADDRESS, bus.IN)), 32'(q.pop_front()));
      end
   end

   initial begin
      bus.REQ0 = 0; bus.ADDR0 = '0; bus.DATA0 = '0;
      bus.REQ1 = 0; bus.ADDR1 = '0; bus.DATA1 = '0;
      bus.CLEAR = 0;
      #12;
      chk("reset_outputs", {bus.GNT0, bus.GNT1, bus.WRITE, bus.BUSY, 8'(bus.INADDRESS), bus.IN}, 32'h0);
      RESET = 1'b1;
      step();
      // reset during the third clear cycle: only clear writes 0 and 1 are observed
      bus.CLEAR = 1;
      q.push_back(ev(0, 0, 1, 0, 0));
      q.push_back(ev(0, 0, 1, 1, 0));
      step();
      bus.CLEAR = 0;
      step();
      step();
      #2;
      RESET = 1'b0;
      #1;
      chk("reset_mid_clear", {bus.GNT0, bus.GNT1, bus.WRITE, bus.BUSY, 8'(bus.INADDRESS), bus.IN}, 32'h0);
      step();
      RESET = 1'b1;
      step();
      step();
      chk("busy_after_reset", bus.BUSY, 0);
      chk("no_resume_sb", q.size(), 0);
      // contention: both held for four edges, LAST starts at 1
      bus.REQ0 = 1; bus.ADDR0 = 1; bus.DATA0 = 50;
      bus.REQ1 = 1; bus.ADDR1 = 7; bus.DATA1 = 40;
      for (int i = 0; i < 4; i++)
         q.push_back((i % 2) == 0 ? ev(1, 0, 1, 1, 50) : ev(0, 1, 1, 7, 40));
      for (int i = 0; i < 4; i++) step();
      bus.REQ0 = 0; bus.REQ1 = 0;
      step();
      chk("rf1_contention", rf[1], 50);
      chk("rf7_contention", rf[7], 40);
      chk("contention_sb", q.size(), 0);
      // single requester
      bus.REQ0 = 1; bus.ADDR0 = 3; bus.DATA0 = 56;
      q.push_back(ev(1, 0, 1, 3, 56));
      step();
      chk("single_gnt0", {bus.GNT0, bus.GNT1, bus.WRITE}, 3'b101);
      bus.REQ0 = 0;
      step();
      chk("rf3_single", rf[3], 56);
      step();
      chk("single_no_regrant", bus.GNT0, 0);
      // clear and request together; CLEAR re-asserted mid-clear must be ignored
      busy_cnt = 0;
      bus.CLEAR = 1;
      bus.REQ1 = 1; bus.ADDR1 = 5; bus.DATA1 = 9;
      for (int c = 0; c < NUM_REGS; c++) q.push_back(ev(0, 0, 1, ADDR_W'(c), 0));
      q.push_back(ev(0, 1, 1, 5, 9));
      step();
      bus.CLEAR = 0;
      chk("busy_start", bus.BUSY, 1);
      for (int i = 1; i <= NUM_REGS; i++) begin
         step();
         if (i == 3) bus.CLEAR = 1;
         if (i == 5) bus.CLEAR = 0;
      end
      chk("gnt1_after_clear", {bus.GNT1, bus.BUSY}, 2'b10);
      bus.REQ1 = 0;
      step();
      step();
      chk("busy_cycles", busy_cnt, NUM_REGS);
      chk("clear_sb", q.size(), 0);
      chk("rf1_cleared", rf[1], 0);
      chk("rf7_cleared", rf[7], 0);
      chk("rf3_cleared", rf[3], 0);
      chk("rf5_written", rf[5], 9);
      // register 0 write
      bus.REQ1 = 1; bus.ADDR1 = 0; bus.DATA1 = 85;
`ifdef PROTECT_R0_EN
      q.push_back(ev(0, 1, 0, 0, 85));
`else
      q.push_back(ev(0, 1, 1, 0, 85));
`endif
      step();
      bus.REQ1 = 0;
      step();
`ifdef PROTECT_R0_EN
      chk("rf0_protected", rf[0], 0);
`else
      chk("rf0_written", rf[0], 85);
`endif
      for (int i = 0; i < 3; i++) step();
      chk("final_sb_empty", q.size(), 0);
      chk("idle_quiet", {bus.GNT0, bus.GNT1, bus.WRITE, bus.BUSY}, 4'b0000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
